// File: rtl/mm_mul_pkg.sv
// Shared types and constants for the mm_mul matrix-product engine.
//   fp32_t      : raw IEEE-754 binary32 bit pattern
//   FP32_QNAN   : canonical quiet NaN produced by every invalid operation
//   FP32_PZERO  : +0.0, reset value of the accumulator and the result array
//   EXP_BIAS    : binary32 exponent bias
//   state_t     : controller states IDLE / CALC / DONE
package mm_mul_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_QNAN  = 32'h7FC0_0000;
  localparam fp32_t FP32_PZERO = 32'h0000_0000;
  localparam int    EXP_BIAS   = 127;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/mm_mul_fp32_mac.sv
// fp32_mac: combinational binary32 multiply-accumulate, sum = round(acc + round(a*b)).
// Ports:
//   a, b : multiplicand / multiplier (binary32)
//   acc  : running sum (binary32)
//   sum  : new running sum (binary32)
// Denormals flush to signed zero, overflow saturates to +/-Inf, NaN operands,
// Inf*0 and Inf-Inf give the canonical qNaN, an exact zero sum is +0.0.
// Build option MM_MUL_RNE_EN: defined -> round to nearest, ties to even;
// undefined -> truncate toward zero.
module fp32_mac
  import mm_mul_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  input  fp32_t acc,
  output fp32_t sum
);

`ifdef MM_MUL_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  localparam logic signed [9:0] BIAS = 10'(EXP_BIAS);

  // m carries the hidden bit; g is the first dropped bit, st the OR of the rest.
  // Range checks run after rounding so a carry-out can still overflow to Inf.
  function automatic fp32_t round_pack(input logic s, input logic signed [9:0] e,
                                       input logic [23:0] m, input logic g,
                                       input logic st);
    logic [24:0]        mr;
    logic signed [9:0]  er;
    mr = {1'b0, m};
    er = e;
    if (RNE && g && (st || m[0])) mr = mr + 25'd1;
    if (mr[24]) begin
      mr = mr >> 1;
      er = er + 10'sd1;
    end
    if (er >= 10'sd255) return {s, 8'hFF, 23'h0};
    if (er <= 10'sd0)   return {s, 31'h0};
    return {s, er[7:0], mr[22:0]};
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] z;
    z = 5'd0;
    for (int n = 0; n < 27; n++) if (v[n]) z = 5'(26 - n);
    return z;
  endfunction

  function automatic fp32_t fp_mul(input fp32_t x, input fp32_t y);
    logic              s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic [47:0]       p;
    logic signed [9:0] e;
    s      = x[31] ^ y[31];
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != '0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != '0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == '0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == '0);
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) return FP32_QNAN;
    if (x_inf || y_inf)   return {s, 8'hFF, 23'h0};
    if (x_zero || y_zero) return {s, 31'h0};
    p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
    e = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - BIAS;
    // Product of two [1,2) mantissas lies in [1,4): at most one normalising shift.
    if (p[47]) return round_pack(s, e + 10'sd1, p[47:24], p[23], |p[22:0]);
    return round_pack(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic fp32_t fp_add(input fp32_t x, input fp32_t y);
    logic              x_nan, y_nan, x_inf, y_inf, swap, sub, sb;
    logic [7:0]        eb, es, d;
    logic [23:0]       mb, ms;
    logic [4:0]        sh, lz;
    logic [53:0]       wide;
    logic [26:0]       sm, n;
    logic [27:0]       r;
    logic signed [9:0] e;
    x_nan = (x[30:23] == 8'hFF) && (x[22:0] != '0);
    y_nan = (y[30:23] == 8'hFF) && (y[22:0] != '0);
    x_inf = (x[30:23] == 8'hFF) && (x[22:0] == '0);
    y_inf = (y[30:23] == 8'hFF) && (y[22:0] == '0);
    if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) return FP32_QNAN;
    if (x_inf) return {x[31], 8'hFF, 23'h0};
    if (y_inf) return {y[31], 8'hFF, 23'h0};
    if ((x[30:23] == 8'h00) && (y[30:23] == 8'h00)) return FP32_PZERO;
    if (x[30:23] == 8'h00) return y;
    if (y[30:23] == 8'h00) return x;
    swap = (y[30:0] > x[30:0]);
    sb   = swap ? y[31] : x[31];
    sub  = x[31] ^ y[31];
    eb   = swap ? y[30:23] : x[30:23];
    es   = swap ? x[30:23] : y[30:23];
    mb   = {1'b1, swap ? y[22:0] : x[22:0]};
    ms   = {1'b1, swap ? x[22:0] : y[22:0]};
    d    = eb - es;
    // Align the smaller operand into 24 bits + guard/round/sticky; everything
    // shifted below the sticky position is OR-ed into it.
    sh   = (d > 8'd27) ? 5'd27 : d[4:0];
    wide = {ms, 30'h0} >> sh;
    sm   = {wide[53:28], wide[27] | (|wide[26:0])};
    r    = sub ? ({1'b0, mb, 3'b000} - {1'b0, sm}) : ({1'b0, mb, 3'b000} + {1'b0, sm});
    if (r == '0) return FP32_PZERO;
    e = $signed({2'b00, eb});
    if (r[27]) begin
      n = {r[27:2], r[1] | r[0]};
      e = e + 10'sd1;
    end else begin
      // Large left shifts only occur for d<=1, where no sticky bit was formed.
      lz = lzc27(r[26:0]);
      n  = r[26:0] << lz;
      e  = e - $signed({5'b00000, lz});
    end
    return round_pack(sb, e, n[26:3], n[2], |n[1:0]);
  endfunction

  assign sum = fp_add(acc, fp_mul(a, b));

endmodule

// File: rtl/mm_mul.sv
// mm_mul: sequential binary32 matrix product, result = matrix1 x matrix2,
// one multiply-accumulate per clock through a single fp32_mac.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   enable  : start request (level); must drop for a cycle between runs
//   matrix1 : [ROWS1][COLS1] binary32 operand, captured when a run starts
//   matrix2 : [ROWS2][COLS2] binary32 operand, captured when a run starts
//   result  : [ROWS1][COLS2] binary32 product, registered
//   done    : result valid; high from the end of a run until enable drops
// Build option MM_MUL_RNE_EN selects round-to-nearest-even inside fp32_mac
// (default build truncates).
module mm_mul
  import mm_mul_pkg::*;
#(
  parameter int ROWS1 = 4,
  parameter int COLS1 = 4,
  parameter int ROWS2 = 4,
  parameter int COLS2 = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [ROWS1-1:0][COLS1-1:0][31:0]    matrix1,
  input  logic [ROWS2-1:0][COLS2-1:0][31:0]    matrix2,
  output logic [ROWS1-1:0][COLS2-1:0][31:0]    result,
  output logic                                 done
);

  if (ROWS2 != COLS1) begin : g_dim_check
    $error("mm_mul: ROWS2 must equal COLS1");
  end

  localparam int IW = (ROWS1 > 1) ? $clog2(ROWS1) : 1;
  localparam int JW = (COLS2 > 1) ? $clog2(COLS2) : 1;
  localparam int KW = (COLS1 > 1) ? $clog2(COLS1) : 1;

  state_t                                r_state;
  logic [ROWS1-1:0][COLS1-1:0][31:0]     r_m1;
  logic [ROWS2-1:0][COLS2-1:0][31:0]     r_m2;
  logic [ROWS1-1:0][COLS2-1:0][31:0]     r_result;
  fp32_t                                 r_acc;
  logic [IW-1:0]                         r_i;
  logic [JW-1:0]                         r_j;
  logic [KW-1:0]                         r_k;
  logic                                  r_fin;
  logic                                  r_done;
  fp32_t                                 w_sum;

  fp32_mac u_mac (
    .a   (r_m1[r_i][r_k]),
    .b   (r_m2[r_k][r_j]),
    .acc (r_acc),
    .sum (w_sum)
  );

  // Operand snapshot: plain data, loaded only when a run is accepted.
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && enable) begin
      r_m1 <= matrix1;
      r_m2 <= matrix2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_done   <= 1'b0;
      r_acc    <= FP32_PZERO;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_fin    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (enable) begin
            r_acc   <= FP32_PZERO;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_fin   <= 1'b0;
            r_state <= CALC;
          end
        end
        CALC: begin
          // r_fin spends one extra cycle after the last write so that done
          // rises on edge ROWS1*COLS2*COLS1+1 after the start.
          if (r_fin) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (r_k == KW'(COLS1 - 1)) begin
            r_result[r_i][r_j] <= w_sum;
            r_acc              <= FP32_PZERO;
            r_k                <= '0;
            if (r_j == JW'(COLS2 - 1)) begin
              r_j <= '0;
              if (r_i == IW'(ROWS1 - 1)) begin
                r_i   <= '0;
                r_fin <= 1'b1;
              end else begin
                r_i <= r_i + IW'(1);
              end
            end else begin
              r_j <= r_j + JW'(1);
            end
          end else begin
            r_acc <= w_sum;
            r_k   <= r_k + KW'(1);
          end
        end
        DONE: begin
          if (!enable) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: tb/tb_mm_mul.sv
// Testbench for mm_mul (4x4 default). Stimulus pushes the expected product
// and completion cycle into a scoreboard queue; a negedge monitor pops and
// compares whenever done rises. The reference model works on real numbers:
// each product and each partial sum is formed exactly in double precision and
// then rounded to binary32 (ties-to-even when MM_MUL_RNE_EN is defined,
// toward zero otherwise). Random operands are confined to magnitudes in
// [1/8, 16) so every exact intermediate fits a double.
module tb_mm_mul;

  localparam int N = 4;
  typedef logic [N-1:0][N-1:0][31:0] mat_t;

`ifdef MM_MUL_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] ONE  = 32'h3F80_0000;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  mat_t matrix1, matrix2, result;
  logic done;

  mm_mul #(.ROWS1(N), .COLS1(N), .ROWS2(N), .COLS2(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .matrix1 (matrix1),
    .matrix2 (matrix2),
    .result  (result),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    mat_t res;
    int   due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  mat_t last_exp;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  function automatic bit is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
  endfunction

  function automatic bit is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e11;
    if (is_zero(x)) return 0.0;
    e11 = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e11, x[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic        g, st;
    int          e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'h0};
    e  = int'(d[62:52]) - 1023 + 127;
    m  = {2'b01, d[51:29]};
    g  = d[28];
    st = |d[27:0];
    if (RNE && g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0)   return {d[63], 31'h0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] x, input logic [31:0] y);
    logic s;
    s = x[31] ^ y[31];
    if (is_nan(x) || is_nan(y)) return QNAN;
    if ((is_inf(x) && is_zero(y)) || (is_inf(y) && is_zero(x))) return QNAN;
    if (is_inf(x) || is_inf(y)) return {s, 8'hFF, 23'h0};
    if (is_zero(x) || is_zero(y)) return {s, 31'h0};
    return to_f32(f2r(x) * f2r(y));
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
    real r;
    if (is_nan(x) || is_nan(y)) return QNAN;
    if (is_inf(x) && is_inf(y) && (x[31] != y[31])) return QNAN;
    if (is_inf(x)) return x;
    if (is_inf(y)) return y;
    r = f2r(x) + f2r(y);
    if (r == 0.0) return 32'h0;
    return to_f32(r);
  endfunction

  function automatic mat_t model(input mat_t a, input mat_t b);
    mat_t        r;
    logic [31:0] acc;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 32'h0;
        for (int k = 0; k < N; k++) acc = m_add(acc, m_mul(a[i][k], b[k][j]));
        r[i][j] = acc;
      end
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rnd_f();
    logic [31:0] v;
    v[31]    = 1'($urandom);
    v[30:23] = 8'($urandom_range(130, 124));
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  function automatic mat_t rnd_mat();
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = rnd_f();
    return m;
  endfunction

  function automatic mat_t fill(input logic [31:0] v);
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat_t diag(input logic [31:0] v);
    mat_t m;
    m = '0;
    for (int i = 0; i < N; i++) m[i][i] = v;
    return m;
  endfunction

  task automatic start(input mat_t a, input mat_t b);
    exp_t e;
    matrix1 = a;
    matrix2 = b;
    enable  = 1'b1;
    @(posedge clk);
    #1;
    e.res    = model(a, b);
    e.due    = cyc + N * N * N + 1;
    last_exp = e.res;
    sbq.push_back(e);
  endtask

  task automatic drain(input bit scramble, input int drop_at);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (scramble) begin
        matrix1 = rnd_mat();
        matrix2 = rnd_mat();
      end
      if (n == drop_at) enable = 1'b0;
    end
    chk("sb_drain", sbq.size(), 0);
  endtask

  task automatic finish_run();
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("done_low", done, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (done === 1'b1 && prev_done !== 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 1'b1, 1'b0);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_latency", cyc, mon_e.due);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            chk($sformatf("res[%0d][%0d]", i, j), result[i][j], mon_e.res[i][j]);
      end
    end
    prev_done = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    mat_t a, b;
    rst     = 1'b1;
    enable  = 1'b0;
    matrix1 = '0;
    matrix2 = '0;
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // identity x identity
    start(diag(ONE), diag(ONE));
    drain(1'b0, 0);
    chk("id_diag", result[2][2], ONE);
    chk("id_offdiag", result[2][1], 32'h0);
    finish_run();

    // integer matrix times 2I
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) a[i][j] = to_f32(real'(N * i + j + 1));
    start(a, diag(32'h4000_0000));
    drain(1'b0, 0);
    chk("twoA_33", result[3][3], 32'h4200_0000);
    finish_run();

    // 0.5 x -1.5 with inputs scrambled and enable dropped during CALC
    start(fill(32'h3F00_0000), fill(32'hBFC0_0000));
    drain(1'b1, 3);
    chk("neg3_12", result[1][2], 32'hC040_0000);
    finish_run();

    // reset in the middle of CALC, then a clean run
    start(rnd_mat(), rnd_mat());
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_done", done, 1'b0);
    chk("midrst_result", result, '0);
    sbq.delete();
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start(rnd_mat(), rnd_mat());
    drain(1'b0, 0);
    finish_run();

    // enable held past done, then dropped, then a new run
    start(rnd_mat(), rnd_mat());
    drain(1'b0, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("hold_done", done, 1'b1);
      chk("hold_result", result, last_exp);
    end
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_done", done, 1'b0);
    chk("drop_result", result, last_exp);
    start(rnd_mat(), rnd_mat());
    drain(1'b0, 0);
    finish_run();

    // NaN operand poisons row 0 only
    a = rnd_mat();
    b = rnd_mat();
    a[0][0] = 32'h7FC1_2345;
    start(a, b);
    drain(1'b0, 0);
    chk("nan_row0", result[0][3], QNAN);
    finish_run();

    // Inf times zero poisons row 0 only
    a = rnd_mat();
    b = rnd_mat();
    a[0][0] = 32'h7F80_0000;
    b[0]    = '0;
    start(a, b);
    drain(1'b0, 0);
    chk("inf0_row0", result[0][1], QNAN);
    finish_run();

    // 1 + 2^-23 + 2^-24: a tie that separates the two rounding builds
    a = rnd_mat();
    a[0][0] = ONE;
    a[0][1] = 32'h3400_0000;
    a[0][2] = 32'h3380_0000;
    a[0][3] = 32'h0;
    start(a, fill(ONE));
    drain(1'b0, 0);
    chk("tie_round", result[0][1], RNE ? 32'h3F80_0002 : 32'h3F80_0001);
    finish_run();

    // random operands
    for (int t = 0; t < 4; t++) begin
      start(rnd_mat(), rnd_mat());
      drain(1'b0, 0);
      finish_run();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
